// File: rtl/dacx311_rx_if.sv
// DACx311 SPI target bus: SPI pins from the master plus decoded frame outputs.
// Optional statistics outputs are present when DACX311_RX_STATS_EN is defined.
interface dacx311_rx_if;
    logic        sclk;
    logic        mosi;
    logic        ss;
    logic [1:0]  pd;
    logic [11:0] data;
    logic        valid;
    logic        err;
    logic        busy;
`ifdef DACX311_RX_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    modport master (
        output sclk, mosi, ss,
        input  pd, data, valid, err, busy, frame_cnt, err_cnt
    );
    modport slave (
        input  sclk, mosi, ss,
        output pd, data, valid, err, busy, frame_cnt, err_cnt
    );
`else
    modport master (
        output sclk, mosi, ss,
        input  pd, data, valid, err, busy
    );
    modport slave (
        input  sclk, mosi, ss,
        output pd, data, valid, err, busy
    );
`endif
endinterface

// File: rtl/dacx311_rx.sv
// Oversampled SPI target decoding DACx311 frames (PD[1:0], D[11:0], 2 pad bits, MSB first).
// All SPI pins are synchronised into clk; nothing is clocked by sclk.
// Optional: define DACX311_RX_STATS_EN to add frame_cnt / err_cnt outputs.
module dacx311_rx #(
    parameter logic        CPOL        = 1'b0,
    parameter logic        SS          = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic         clk,
    input logic         reset,
    dacx311_rx_if.slave bus
);

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned PD_W       = 2;
    localparam int unsigned DATA_W     = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_hist;
    logic                   ss_hist;

    logic sclk_s;
    logic mosi_s;
    logic ss_s;
    logic sample_edge_c;
    logic ss_act_c;
    logic ss_rise_c;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [FRAME_BITS-1:0]   sr, sr_d;
    logic                    ovr, ovr_d;
    logic [PD_W-1:0]         pd_r, pd_d;
    logic [DATA_W-1:0]       data_r, data_d;
    logic                    valid_r, valid_d;
    logic                    err_r, err_d;
    logic                    busy_r, busy_d;
`ifdef DACX311_RX_STATS_EN
    logic [15:0]             frame_cnt_r, frame_cnt_d;
    logic [7:0]              err_cnt_r, err_cnt_d;
`endif

    // Synchronisers; ss resets to its active level so a select already active
    // at reset release is not mistaken for a new frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            mosi_sync <= '0;
            ss_sync   <= {SYNC_STAGES{SS}};
            sclk_hist <= CPOL;
            ss_hist   <= SS;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            ss_hist   <= ss_sync[SYNC_STAGES-1];
        end
    end

    // Edge and level decode on the synchronised pins (mosi matches sclk latency).
    always_comb begin
        sclk_s        = sclk_sync[SYNC_STAGES-1];
        mosi_s        = mosi_sync[SYNC_STAGES-1];
        ss_s          = ss_sync[SYNC_STAGES-1];
        sample_edge_c = (sclk_hist != CPOL) && (sclk_s == CPOL);
        ss_act_c      = (ss_s == SS);
        ss_rise_c     = ss_act_c && (ss_hist != SS);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            ovr     <= 1'b0;
            pd_r    <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
`ifdef DACX311_RX_STATS_EN
            frame_cnt_r <= '0;
            err_cnt_r   <= '0;
`endif
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            sr      <= sr_d;
            ovr     <= ovr_d;
            pd_r    <= pd_d;
            data_r  <= data_d;
            valid_r <= valid_d;
            err_r   <= err_d;
            busy_r  <= busy_d;
`ifdef DACX311_RX_STATS_EN
            frame_cnt_r <= frame_cnt_d;
            err_cnt_r   <= err_cnt_d;
`endif
        end
    end

    // Next-state and next-output logic; ss deassert wins over a coincident edge.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sr_d    = sr;
        ovr_d   = ovr;
        pd_d    = pd_r;
        data_d  = data_r;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state)
            IDLE: begin
                if (ss_rise_c) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                    ovr_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(FRAME_BITS)) begin
                    pd_d    = sr[15:14];
                    data_d  = sr[13:2];
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (!ss_act_c) begin
                    err_d   = (cnt != '0);
                    state_d = IDLE;
                end else if (sample_edge_c) begin
                    sr_d  = {sr[FRAME_BITS-2:0], mosi_s};
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (!ss_act_c) begin
                    state_d = IDLE;
                end else if (sample_edge_c && !ovr) begin
                    err_d = 1'b1;
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

`ifdef DACX311_RX_STATS_EN
    // Frame counter wraps; error counter saturates.
    always_comb begin
        frame_cnt_d = frame_cnt_r + 16'(valid_d);
        err_cnt_d   = err_cnt_r;
        if (err_d && (err_cnt_r != 8'hFF)) begin
            err_cnt_d = err_cnt_r + 8'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_r;
    assign bus.err_cnt   = err_cnt_r;
`endif

    assign bus.pd    = pd_r;
    assign bus.data  = data_r;
    assign bus.valid = valid_r;
    assign bus.err   = err_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_dacx311_rx.sv
// Bench for dacx311_rx: a CPOL=0/SS=1 and a CPOL=1/SS=0 instance receive the same
// frames (second instance sees inverted sclk/ss) and are checked against a frame-level model.
module tb_dacx311_rx;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned LATENCY     = SYNC_STAGES + 2;
    localparam int unsigned HALF_SCLK   = 4;

    logic clk;
    logic reset;
    logic sclk_a;
    logic mosi;
    logic ss_a;

    dacx311_rx_if if_a ();
    dacx311_rx_if if_b ();

    assign if_a.sclk = sclk_a;
    assign if_a.mosi = mosi;
    assign if_a.ss   = ss_a;
    assign if_b.sclk = ~sclk_a;
    assign if_b.mosi = mosi;
    assign if_b.ss   = ~ss_a;

    dacx311_rx #(.CPOL(1'b0), .SS(1'b1), .SYNC_STAGES(SYNC_STAGES)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    dacx311_rx #(.CPOL(1'b1), .SS(1'b0), .SYNC_STAGES(SYNC_STAGES)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Pulse monitor, written only here.
    int vcnt_a = 0, ecnt_a = 0, both_a = 0, lat_a = 0;
    int vcnt_b = 0, ecnt_b = 0, both_b = 0, lat_b = 0;
    int edge16_cyc = 0;

    always @(negedge clk) begin
        if (if_a.valid) begin
            vcnt_a = vcnt_a + 1;
            lat_a  = cyc - edge16_cyc;
        end
        if (if_a.err) ecnt_a = ecnt_a + 1;
        if (if_a.valid && if_a.err) both_a = both_a + 1;
        if (if_b.valid) begin
            vcnt_b = vcnt_b + 1;
            lat_b  = cyc - edge16_cyc;
        end
        if (if_b.err) ecnt_b = ecnt_b + 1;
        if (if_b.valid && if_b.err) both_b = both_b + 1;
    end

    // Reference model state: last good frame and event totals since reset.
    logic [1:0]  exp_pd   = '0;
    logic [11:0] exp_data = '0;
    int          exp_frames = 0;
    int          exp_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk = n_chk + 1;
        if (obs !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs(input int dv_a, input int de_a, input int dv_b, input int de_b,
                                 input int exp_v, input int exp_e);
        chk("valid_cnt_a", 32'(dv_a), 32'(exp_v));
        chk("err_cnt_a",   32'(de_a), 32'(exp_e));
        chk("valid_cnt_b", 32'(dv_b), 32'(exp_v));
        chk("err_cnt_b",   32'(de_b), 32'(exp_e));
        chk("pd_a",   32'(if_a.pd),   32'(exp_pd));
        chk("data_a", 32'(if_a.data), 32'(exp_data));
        chk("pd_b",   32'(if_b.pd),   32'(exp_pd));
        chk("data_b", 32'(if_b.data), 32'(exp_data));
        chk("busy_a_idle", 32'(if_a.busy), 32'd0);
        chk("busy_b_idle", 32'(if_b.busy), 32'd0);
        chk("valid_err_overlap_a", 32'(both_a), 32'd0);
        chk("valid_err_overlap_b", 32'(both_b), 32'd0);
`ifdef DACX311_RX_STATS_EN
        chk("frame_cnt_a", 32'(if_a.frame_cnt), 32'(exp_frames % 65536));
        chk("frame_cnt_b", 32'(if_b.frame_cnt), 32'(exp_frames % 65536));
        chk("stat_err_a",  32'(if_a.err_cnt), 32'((exp_errs > 255) ? 255 : exp_errs));
        chk("stat_err_b",  32'(if_b.err_cnt), 32'((exp_errs > 255) ? 255 : exp_errs));
`endif
    endtask

    // One SPI sampling period: mosi changes on the leading edge, sampled on the return edge.
    task automatic sclk_bit(input logic b, input bit mark16);
        sclk_a = 1'b1;
        mosi   = b;
        repeat (HALF_SCLK) @(negedge clk);
        sclk_a = 1'b0;
        if (mark16) edge16_cyc = cyc;
        repeat (HALF_SCLK) @(negedge clk);
    endtask

    // Send one ss window with n sampling edges; bits past the 16th are random.
    task automatic run_frame(input logic [15:0] word, input int n);
        int v0a, e0a, v0b, e0b;
        int ev, ee;
        logic b;
        v0a = vcnt_a; e0a = ecnt_a; v0b = vcnt_b; e0b = ecnt_b;
        @(negedge clk);
        ss_a = 1'b1;
        repeat (HALF_SCLK) @(negedge clk);
        chk("busy_a_active", 32'(if_a.busy), 32'd1);
        chk("busy_b_active", 32'(if_b.busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            b = (i < 16) ? word[15 - i] : 1'($urandom);
            sclk_bit(b, i == 15);
        end
        ss_a = 1'b0;
        repeat (4 * HALF_SCLK) @(negedge clk);

        ev = (n >= 16) ? 1 : 0;
        ee = ((n >= 1 && n <= 15) || n > 16) ? 1 : 0;
        if (ev == 1) begin
            exp_pd     = word[15:14];
            exp_data   = word[13:2];
            exp_frames = exp_frames + 1;
            chk("latency_a", 32'(lat_a), 32'(LATENCY));
            chk("latency_b", 32'(lat_b), 32'(LATENCY));
        end
        exp_errs = exp_errs + ee;
        check_outputs(vcnt_a - v0a, ecnt_a - e0a, vcnt_b - v0b, ecnt_b - e0b, ev, ee);
    endtask

    // Reset mid-frame after 7 edges, released with ss active, then the other 9 edges.
    task automatic reset_mid_frame(input logic [15:0] word);
        int v0a, e0a, v0b, e0b;
        @(negedge clk);
        ss_a = 1'b1;
        repeat (HALF_SCLK) @(negedge clk);
        for (int i = 0; i < 7; i++) sclk_bit(word[15 - i], 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_pd = '0; exp_data = '0; exp_frames = 0; exp_errs = 0;
        v0a = vcnt_a; e0a = ecnt_a; v0b = vcnt_b; e0b = ecnt_b;
        for (int i = 7; i < 16; i++) sclk_bit(word[15 - i], 1'b0);
        chk("busy_a_after_rst", 32'(if_a.busy), 32'd0);
        ss_a = 1'b0;
        repeat (4 * HALF_SCLK) @(negedge clk);
        check_outputs(vcnt_a - v0a, ecnt_a - e0a, vcnt_b - v0b, ecnt_b - e0b, 0, 0);
    endtask

    initial begin
        int n;
        int pick;
        logic [15:0] w;

        reset  = 1'b1;
        sclk_a = 1'b0;
        mosi   = 1'b0;
        ss_a   = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        chk("rst_pd_a",    32'(if_a.pd),    32'd0);
        chk("rst_data_a",  32'(if_a.data),  32'd0);
        chk("rst_valid_a", 32'(if_a.valid), 32'd0);
        chk("rst_err_a",   32'(if_a.err),   32'd0);
        chk("rst_busy_a",  32'(if_a.busy),  32'd0);
        chk("rst_busy_b",  32'(if_b.busy),  32'd0);
        chk("rst_pulses",  32'(vcnt_a + ecnt_a + vcnt_b + ecnt_b), 32'd0);

        run_frame(16'h6970, 16);
        run_frame({2'b11, 12'h000, 2'b00}, 16);
        run_frame({2'b11, 12'hFFF, 2'b00}, 16);
        run_frame({2'b10, 12'h3C3, 2'b01}, 9);
        run_frame({2'b10, 12'h123, 2'b00}, 20);
        run_frame(16'h0000, 0);
        reset_mid_frame(16'hBEEF);
        run_frame({2'b00, 12'h7E1, 2'b00}, 16);

        for (int k = 0; k < 24; k++) begin
            pick = int'($urandom_range(0, 5));
            case (pick)
                0:       n = 0;
                1:       n = int'($urandom_range(1, 15));
                4:       n = int'($urandom_range(17, 20));
                default: n = 16;
            endcase
            w = 16'($urandom);
            run_frame(w, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
